corefifo_wr_skid: RTL

COREFIFO_WR_SKID -- requirements
Module: corefifo_wr_skid

---
 rtl/corefifo_pkg.sv | 18 +
 rtl/corefifo_wr_stat.sv | 38 +++
 rtl/corefifo_wr_skid.sv | 101 ++++++++++
 3 files changed

// File: rtl/corefifo_pkg.sv
// Shared definitions for the corefifo write-side blocks: skid FSM state
// encodings, statistics counter widths and a saturating increment helper.
package corefifo_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    localparam int WR_CNT_W   = 16;
    localparam int DROP_CNT_W = 8;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/corefifo_wr_stat.sv
// Write-side statistics: wrapping write counter, saturating drop counter and
// a sticky overflow flag cleared by clr_ovf.
module corefifo_wr_stat
    import corefifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_pulse,
    input  logic                  drop_pulse,
    input  logic                  clr_ovf,
    output logic                  overflow,
    output logic [WR_CNT_W-1:0]   wr_count,
    output logic [DROP_CNT_W-1:0] drop_count
);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            wr_count   <= '0;
            drop_count <= '0;
        end else begin
            if (wr_pulse)
                wr_count <= wr_count + 1'b1;

            // A drop coinciding with a clear restarts the count at one.
            if (drop_pulse) begin
                overflow   <= 1'b1;
                drop_count <= clr_ovf ? DROP_CNT_W'(1) : sat_inc(drop_count);
            end else if (clr_ovf) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule

// File: rtl/corefifo_wr_skid.sv
// Two-entry skid buffer in front of a FIFO write port: absorbs the registered
// full flag, optionally discarding words instead of back-pressuring.
module corefifo_wr_skid
    import corefifo_pkg::*;
#(
    parameter int WWIDTH       = 10,
    parameter bit WRITE_LOW    = 1'b1,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [WWIDTH-1:0]     s_data,
    output logic                  s_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [WWIDTH-1:0]     fifo_din,
    input  logic                  clr_ovf,
    output logic                  idle,
    output logic                  overflow,
    output logic [WR_CNT_W-1:0]   wr_count,
    output logic [DROP_CNT_W-1:0] drop_count
);

    state_t            state, state_nxt;
    logic [WWIDTH-1:0] main_q, main_nxt;
    logic [WWIDTH-1:0] skid_q, skid_nxt;
    logic              accept, drain, drop;

    // Outputs are forced to their quiet values while reset is asserted.
    assign s_ready    = !rst && (DROP_ON_FULL || state != ST_TWO);
    assign accept     = s_valid && s_ready;
    assign drain      = !rst && state != ST_EMPTY && !fifo_full;
    assign fifo_wr_en = WRITE_LOW ? !drain : drain;
    assign fifo_din   = rst ? '0 : main_q;
    assign idle       = rst || state == ST_EMPTY;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        drop      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    main_nxt  = s_data;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_nxt = s_data;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    skid_nxt  = s_data;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Accept in this state is only possible in drop mode.
                if (drain) begin
                    main_nxt = skid_q;
                    if (accept)
                        skid_nxt = s_data;
                    else
                        state_nxt = ST_ONE;
                end else if (accept) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    corefifo_wr_stat u_stat (
        .clk        (clk),
        .rst        (rst),
        .wr_pulse   (drain),
        .drop_pulse (drop),
        .clr_ovf    (clr_ovf),
        .overflow   (overflow),
        .wr_count   (wr_count),
        .drop_count (drop_count)
    );

endmodule
